// File: rtl/csr_file.sv
// Machine-mode CSR file: counter reads, trap CSRs, trap/mret redirect.
// Read data and the illegal flag are returned registered into MEM.
module csr_file #(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            csr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            csr_src_zero,
  input  logic [63:0]     cycle_cnt,
  input  logic [63:0]     instret_cnt,
  input  logic            stall,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret_req,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [1:0] OpRw = 2'b01;
  localparam logic [1:0] OpRs = 2'b10;
  localparam logic [1:0] OpRc = 2'b11;

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            ill_q, ill_d;
  logic            rv_q, rv_d;
  logic [XLEN-1:0] rpc_q, rpc_d;

  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] rd_val;
  logic [XLEN-1:0] wval;
  logic            legal, ro, cnt;
  logic            wr_try, illegal;

  // mstatus view: MPP hardwired to M, only MIE/MPIE live
  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie_q;
    mstatus_rd[3]     = mie_q;
  end

  // address decode and read mux
  always_comb begin
    rd_val = '0;
    legal  = 1'b1;
    ro     = 1'b0;
    cnt    = 1'b0;
    unique case (csr_addr)
      12'h300: rd_val = mstatus_rd;
      12'h305: rd_val = mtvec_q;
      12'h340: rd_val = mscratch_q;
      12'h341: rd_val = mepc_q;
      12'h342: rd_val = mcause_q;
      12'hC00: begin rd_val = cycle_cnt[31:0];    ro = 1'b1; end
      12'hC80: begin rd_val = cycle_cnt[63:32];   ro = 1'b1; end
      12'hC02: begin rd_val = instret_cnt[31:0];  ro = 1'b1; end
      12'hC82: begin rd_val = instret_cnt[63:32]; ro = 1'b1; end
      12'hB00: begin rd_val = cycle_cnt[31:0];    cnt = 1'b1; end
      12'hB80: begin rd_val = cycle_cnt[63:32];   cnt = 1'b1; end
      12'hB02: begin rd_val = instret_cnt[31:0];  cnt = 1'b1; end
      12'hB82: begin rd_val = instret_cnt[63:32]; cnt = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  // write value and legality
  always_comb begin
    wr_try = (csr_op == OpRw) ||
             (((csr_op == OpRs) || (csr_op == OpRc)) &&
              !csr_src_zero);
    illegal = !legal || (ro && wr_try);
    wval = rd_val;
    unique case (csr_op)
      OpRw:    wval = csr_wdata;
      OpRs:    wval = rd_val | csr_wdata;
      OpRc:    wval = rd_val & ~csr_wdata;
      default: wval = rd_val;
    endcase
  end

  // next state: trap > mret > CSR access
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mscratch_d = mscratch_q;
    rdata_d    = rdata_q;
    ill_d      = 1'b0;
    rv_d       = 1'b0;
    rpc_d      = rpc_q;
    if (trap_req) begin
      mepc_d   = {trap_pc[XLEN-1:2], 2'b00};
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      rv_d     = 1'b1;
      rpc_d    = mtvec_q;
    end else if (mret_req) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
      rv_d   = 1'b1;
      rpc_d  = mepc_q;
    end else if (csr_en) begin
      ill_d   = illegal;
      rdata_d = illegal ? '0 : rd_val;
      if (wr_try && !illegal && !cnt) begin
        case (csr_addr)
          12'h300: begin
            mie_d  = wval[3];
            mpie_d = wval[7];
          end
          12'h305: mtvec_d    = {wval[XLEN-1:2], 2'b00};
          12'h340: mscratch_d = wval;
          12'h341: mepc_d     = {wval[XLEN-1:2], 2'b00};
          12'h342: mcause_d   = wval;
          default: ;
        endcase
      end
    end
  end

  // state registers; stall freezes everything
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= {MTVEC_RESET[XLEN-1:2], 2'b00};
      mepc_q     <= '0;
      mcause_q   <= '0;
      mscratch_q <= '0;
      rdata_q    <= '0;
      ill_q      <= 1'b0;
      rv_q       <= 1'b0;
      rpc_q      <= '0;
    end else if (!stall) begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mscratch_q <= mscratch_d;
      rdata_q    <= rdata_d;
      ill_q      <= ill_d;
      rv_q       <= rv_d;
      rpc_q      <= rpc_d;
    end
  end

  assign csr_rdata      = rdata_q;
  assign csr_illegal    = ill_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: vector table for CSR accesses,
// hand sequences for trap, mret, priority, stall and reset.
module tb_csr_file;

  logic        CLK = 1'b0;
  logic        RST;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_src_zero;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;
  logic        stall;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret_req;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  csr_file #(.XLEN(32), .MTVEC_RESET(32'h0)) dut (
    .CLK(CLK), .RST(RST),
    .csr_en(csr_en), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_src_zero(csr_src_zero),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
    .stall(stall), .trap_req(trap_req),
    .trap_cause(trap_cause), .trap_pc(trap_pc),
    .mret_req(mret_req), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        sz;
    logic [31:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    csr_en = 0; csr_op = 0; csr_addr = 0;
    csr_wdata = 0; csr_src_zero = 0;
    trap_req = 0; mret_req = 0;
  endtask

  task automatic acc(input logic [1:0] op,
                     input logic [11:0] a,
                     input logic [31:0] w,
                     input logic sz);
    csr_en = 1; csr_op = op; csr_addr = a;
    csr_wdata = w; csr_src_zero = sz;
  endtask

  task automatic rd(input string name,
                    input logic [11:0] a,
                    input logic [31:0] exp);
    acc(2'b10, a, 32'h0, 1'b1);
    step();
    chk(name, csr_rdata, exp);
    chk({name, "_ill"}, {31'b0, csr_illegal}, 32'h0);
    idle();
  endtask

  vec_t vt[21];

  initial begin
    vt[0]  = '{2'b01, 12'h340, 32'hA5A5_0001, 0, 32'h0, 0};
    vt[1]  = '{2'b10, 12'h340, 32'h0000_00F0, 0, 32'hA5A5_0001, 0};
    vt[2]  = '{2'b10, 12'h340, 32'h0, 1, 32'hA5A5_00F1, 0};
    vt[3]  = '{2'b10, 12'hC00, 32'h0, 1, 32'hFFFF_FFFF, 0};
    vt[4]  = '{2'b10, 12'hC80, 32'h0, 1, 32'h0000_0001, 0};
    vt[5]  = '{2'b01, 12'hC02, 32'h5, 0, 32'h0, 1};
    vt[6]  = '{2'b10, 12'hC02, 32'h0, 1, 32'h0000_0007, 0};
    vt[7]  = '{2'b10, 12'hC82, 32'h0, 1, 32'h0000_0000, 0};
    vt[8]  = '{2'b01, 12'hB00, 32'h1234, 0, 32'hFFFF_FFFF, 0};
    vt[9]  = '{2'b10, 12'hB00, 32'h0, 1, 32'hFFFF_FFFF, 0};
    vt[10] = '{2'b01, 12'h123, 32'h1, 0, 32'h0, 1};
    vt[11] = '{2'b10, 12'h300, 32'h0, 1, 32'h0000_1800, 0};
    vt[12] = '{2'b10, 12'h300, 32'h8, 0, 32'h0000_1800, 0};
    vt[13] = '{2'b01, 12'h305, 32'h0000_0103, 0, 32'h0, 0};
    vt[14] = '{2'b10, 12'h305, 32'h0, 1, 32'h0000_0100, 0};
    vt[15] = '{2'b01, 12'h341, 32'h0000_1237, 0, 32'h0, 0};
    vt[16] = '{2'b10, 12'h341, 32'h0, 1, 32'h0000_1234, 0};
    vt[17] = '{2'b11, 12'h340, 32'h0000_00F0, 0, 32'hA5A5_00F1, 0};
    vt[18] = '{2'b10, 12'h340, 32'h0, 1, 32'hA5A5_0001, 0};
    vt[19] = '{2'b01, 12'h342, 32'h5, 0, 32'h0, 0};
    vt[20] = '{2'b10, 12'h300, 32'h0, 1, 32'h0000_1808, 0};

    idle();
    stall = 0; trap_cause = 0; trap_pc = 0;
    cycle_cnt = 64'h0000_0001_FFFF_FFFF;
    instret_cnt = 64'h0000_0000_0000_0007;
    RST = 1;
    #3;
    chk("rst_rdata", csr_rdata, 32'h0);
    chk("rst_ill", {31'b0, csr_illegal}, 32'h0);
    chk("rst_rv", {31'b0, redirect_valid}, 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);
    step(); step();
    RST = 0;
    step();

    for (int i = 0; i < 21; i++) begin
      acc(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].sz);
      step();
      chk($sformatf("vec%0d_rd", i), csr_rdata, vt[i].exp_rd);
      chk($sformatf("vec%0d_ill", i),
          {31'b0, csr_illegal}, {31'b0, vt[i].exp_ill});
    end

    // illegal flag is a single cycle; rdata holds on idle
    acc(2'b01, 12'hC02, 32'h5, 0);
    step();
    chk("ill_pulse", {31'b0, csr_illegal}, 32'h1);
    chk("ill_rd0", csr_rdata, 32'h0);
    idle();
    step();
    chk("ill_clear", {31'b0, csr_illegal}, 32'h0);
    chk("idle_hold", csr_rdata, 32'h0);
    rd("mcause5", 12'h342, 32'h5);

    // trap entry
    trap_req = 1; trap_cause = 32'hB; trap_pc = 32'h2006;
    step();
    chk("trap_rv", {31'b0, redirect_valid}, 32'h1);
    chk("trap_rpc", redirect_pc, 32'h0000_0100);
    idle();
    step();
    chk("trap_rv_end", {31'b0, redirect_valid}, 32'h0);
    rd("trap_mepc", 12'h341, 32'h0000_2004);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    rd("trap_mcause", 12'h342, 32'h0000_000B);

    // mret
    mret_req = 1;
    step();
    chk("mret_rv", {31'b0, redirect_valid}, 32'h1);
    chk("mret_rpc", redirect_pc, 32'h0000_2004);
    idle();
    step();
    chk("mret_rv_end", {31'b0, redirect_valid}, 32'h0);
    rd("mret_mstatus", 12'h300, 32'h0000_1888);

    // trap + mret + csr write on one edge: only trap
    trap_req = 1; mret_req = 1;
    trap_cause = 32'h2; trap_pc = 32'h3000;
    acc(2'b01, 12'h340, 32'hDEAD_BEEF, 0);
    step();
    chk("prio_rv", {31'b0, redirect_valid}, 32'h1);
    chk("prio_rpc", redirect_pc, 32'h0000_0100);
    chk("prio_rd_hold", csr_rdata, 32'h0000_1888);
    idle();
    step();
    rd("prio_mscratch", 12'h340, 32'hA5A5_0001);
    rd("prio_mepc", 12'h341, 32'h0000_3000);
    rd("prio_mcause", 12'h342, 32'h0000_0002);
    rd("prio_mstatus", 12'h300, 32'h0000_1880);

    // stall during a CSRRW to mtvec
    acc(2'b01, 12'h305, 32'h0000_0200, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_rd%0d", i), csr_rdata, 32'h0000_1880);
    end
    stall = 0;
    step();
    chk("stall_rel_rd", csr_rdata, 32'h0000_0100);
    idle();
    rd("stall_mtvec", 12'h305, 32'h0000_0200);

    // redirect held through a stall
    trap_req = 1; trap_cause = 32'h3; trap_pc = 32'h40;
    step();
    idle();
    stall = 1;
    step();
    chk("rvstall_a", {31'b0, redirect_valid}, 32'h1);
    step();
    chk("rvstall_b", {31'b0, redirect_valid}, 32'h1);
    chk("rvstall_pc", redirect_pc, 32'h0000_0200);
    stall = 0;
    step();
    chk("rvstall_end", {31'b0, redirect_valid}, 32'h0);

    // async reset while redirect pending
    mret_req = 1;
    step();
    idle();
    chk("prerst_rv", {31'b0, redirect_valid}, 32'h1);
    #2;
    RST = 1;
    #1;
    chk("arst_rv", {31'b0, redirect_valid}, 32'h0);
    chk("arst_rpc", redirect_pc, 32'h0);
    chk("arst_rd", csr_rdata, 32'h0);
    chk("arst_ill", {31'b0, csr_illegal}, 32'h0);
    step();
    RST = 0;
    step();
    chk("post_rv", {31'b0, redirect_valid}, 32'h0);
    rd("post_mtvec", 12'h305, 32'h0);
    rd("post_mstatus", 12'h300, 32'h0000_1800);
    rd("post_mepc", 12'h341, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
